// File: rtl/axi4lite_master_ctrl.sv
// axi4lite_master_ctrl: single-outstanding AXI4-Lite master behind a valid/ready command/response port
// Optional: define AXI_MST_PERF_EN to add saturating wr_cnt/rd_cnt/err_cnt outputs.
module axi4lite_master_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
`ifdef AXI_MST_PERF_EN
  output logic [15:0]             wr_cnt,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             err_cnt,
`endif
  output logic                    RREADY
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr;
  assign AWADDR = addr;
  assign ARADDR = addr;
  // transaction sequencer: one request in flight, every output registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      addr      <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          addr      <= req_addr;
          WDATA     <= req_wdata;
          WSTRB     <= req_wstrb;
          AWVALID   <= req_write;
          WVALID    <= req_write;
          ARVALID   <= !req_write;
          state     <= req_write ? WR : RD_A;
        end
        WR: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY) WVALID <= 1'b0;
          if ((AWREADY || !AWVALID) && (WREADY || !WVALID)) begin
            BREADY <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: if (BVALID) begin
          BREADY    <= 1'b0;
          rsp_resp  <= BRESP;
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RD_A: if (ARREADY) begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b1;
          state   <= RD_R;
        end
        RD_R: if (RVALID) begin
          RREADY    <= 1'b0;
          rsp_resp  <= RRESP;
          rsp_write <= 1'b0;
          rsp_rdata <= RDATA;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXI_MST_PERF_EN
  logic wr_done, rd_done;
  logic [1:0] done_resp;
  assign wr_done   = (state == WR_B) && BVALID;
  assign rd_done   = (state == RD_R) && RVALID;
  assign done_resp = wr_done ? BRESP : RRESP;
  // saturating counters of completed writes, reads and non-OKAY responses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      wr_cnt  <= wr_cnt + 16'(wr_done && wr_cnt != 16'hFFFF);
      rd_cnt  <= rd_cnt + 16'(rd_done && rd_cnt != 16'hFFFF);
      err_cnt <= err_cnt + 16'((wr_done || rd_done) && done_resp != 2'b00 && err_cnt != 16'hFFFF);
    end
  end
`endif
endmodule
